// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg -- shared types and constants for the bit-serial adder.
//   state_t        : FSM state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH  : default operand width
//   cnt_width()    : bits needed to count 0..width-1 (never less than 1)
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder -- single-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial adder (optionally subtractor), one bit per clock,
// LSB first, with valid/ready handshakes on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (accepted only in IDLE)
//   a, b                : WIDTH-bit operands
//   sub                 : 1 = a-b (present only when SERIAL_ADDER_SUB_EN is defined)
//   out_valid/out_ready : result handshake (result held in DONE until taken)
//   sum, cout, overflow : result, final carry, signed overflow
// Build option: define SERIAL_ADDER_SUB_EN to add the sub port and subtraction.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             sub_in;
    logic             fa_s, fa_cout;
    logic [WIDTH-1:0] sum_shift;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // Operands are shifted right each RUN edge, so bit 0 is always the live bit.
    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New result bit enters at the MSB; after WIDTH edges the LSB has arrived at bit 0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_shift = fa_s;
        end else begin : g_wn
            assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction: a + ~b + 1, the +1 coming in as the initial carry.
                    b_d     = b ^ {WIDTH{sub_in}};
                    carry_d = sub_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = sum_shift;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = fa_cout;
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int checks = 0;
    int failures = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
        int           hold;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: two's-complement arithmetic on integers.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] rs, output logic rc, output logic ro);
        int ua, ub, full, sa, sb, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
        if (ms) begin
            full = ua + ((1 << W) - ub);  // a + ~b + 1
            sr   = sa - sb;
        end else begin
            full = ua + ub;
            sr   = sa + sb;
        end
        rs = W'(full);
        rc = ((full >> W) & 1) != 0;
        ro = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    endtask

    // Issue one operation, optionally scrambling inputs during RUN, hold result
    // for 'hold' cycles with out_ready low, then consume it.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                          input int hold, input bit scramble,
                          output logic [W-1:0] rs, output logic rc, output logic ro);
        int lat;
        logic [W-1:0] s0;
        logic c0, o0;
        @(posedge clk); #1;
        chk("in_ready_idle", in_ready, 1);
        a = oa; b = ob; sub = os; in_valid = 1'b1;
        @(posedge clk); #1;  // accepting edge
        in_valid = scramble ? 1'($urandom_range(1)) : 1'b0;
        lat = 0;
        for (int i = 1; i <= 4 * W; i++) begin
            if (scramble) begin
                a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(1));
            end
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
        chk("latency", lat, W);
        in_valid = 1'b1;  // must not be accepted in DONE or in the consume cycle
        rs = sum; rc = cout; ro = overflow;
        s0 = sum; c0 = cout; o0 = overflow;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_stable", {sum, cout, overflow}, {s0, c0, o0});
        end
        out_ready = 1'b1;
        chk("consume_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("idle_after_consume", {out_valid, in_ready}, 2'b01);
    endtask

    vec_t vecs[$];
    logic [W-1:0] rs, es;
    logic rc, ro, ec, eo;

    initial begin
        vecs.push_back('{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0});
        vecs.push_back('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 5});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0});
        vecs.push_back('{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0});
        vecs.push_back('{8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0, 2});
`endif

        // Reset state
        #12;
        chk("rst_state", {out_valid, in_ready, sum, cout, overflow}, {1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].hold, 1'b0, rs, rc, ro);
            chk($sformatf("vec%0d_sum", i), rs, vecs[i].e_sum);
            chk($sformatf("vec%0d_cout", i), rc, vecs[i].e_cout);
            chk($sformatf("vec%0d_ovf", i), ro, vecs[i].e_ovf);
        end

        // Reset mid-RUN at bit 3
        @(posedge clk); #1;
        a = 8'h5A; b = 8'h33; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_run_state", {out_valid, in_ready, sum, cout, overflow}, {1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        chk("rst_held_idle", {out_valid, in_ready}, 2'b01);
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, 0, 1'b0, rs, rc, ro);
        chk("post_rst_sum", {rs, rc, ro}, {8'h02, 1'b0, 1'b0});

        // Reset while result is held in DONE
        @(posedge clk); #1;
        a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (W + 1) @(posedge clk);
        #1;
        chk("done_before_rst", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_done_state", {out_valid, in_ready, sum}, {1'b0, 1'b1, 8'h00});
        #3 rst_n = 1'b1;

        // Random with input scrambling during RUN
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            logic r_s;
            ra = W'($urandom); rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            r_s = 1'($urandom_range(1));
`else
            r_s = 1'b0;
`endif
            run_op(ra, rb, r_s, int'($urandom_range(3)), 1'b1, rs, rc, ro);
            model(ra, rb, r_s, es, ec, eo);
            chk($sformatf("rnd%0d a=%0h b=%0h s=%0b", n, ra, rb, r_s), {rs, rc, ro}, {es, ec, eo});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
